// File: rtl/mux_n_reg.sv
// Registered N-way multiplexer with a valid/ready handshake and a 2-entry skid buffer.
// Out-of-range selects load RESET_VALUE and raise a one-cycle sel_err pulse.
module mux_n_reg #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 4,
  parameter int               SEL_W       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid;
  logic [WIDTH-1:0] word;
  logic             bad;
  logic             accept;
  logic             consume;

  // A select that matches no input falls through to RESET_VALUE and is flagged.
  always_comb begin
    word = RESET_VALUE;
    bad  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        word = in_bus[k*WIDTH +: WIDTH];
        bad  = 1'b0;
      end
    end
  end

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // in_ready and out_valid are registered alongside the state so in_ready never
  // depends combinationally on out_ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= RESET_VALUE;
      skid      <= RESET_VALUE;
      sel_err   <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= RESET_VALUE;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= accept & bad;
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            out_valid <= 1'b1;
            out_data  <= word;
          end
        end
        ONE: begin
          if (accept && consume) begin
            out_data <= word;
          end else if (accept) begin
            state    <= TWO;
            skid     <= word;
            in_ready <= 1'b0;
          end else if (consume) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (consume) begin
            state    <= ONE;
            out_data <= skid;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          out_data  <= RESET_VALUE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_n_reg.sv
// Bench for mux_n_reg: a 4-input and a 3-input instance driven with the same stimulus,
// both compared every cycle against a queue-based model of the handshake.
module tb_mux_n_reg;

  localparam logic [31:0] RVA = 32'h0000_0000;
  localparam logic [31:0] RVB = 32'hDEAD_BEEF;

  logic         clock;
  logic         reset;
  logic [127:0] inBus;
  logic [1:0]   sel;
  logic         inValid;
  logic         outReady;
  logic         flush;

  logic         readyA, validA, errA;
  logic [31:0]  dataA;
  logic         readyB, validB, errB;
  logic [31:0]  dataB;

  int checks   = 0;
  int failures = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] lastA, lastB;
  logic        expErrA, expErrB;

  mux_n_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .RESET_VALUE(RVA)) dutA (
    .clock(clock), .reset(reset), .in_bus(inBus), .sel(sel), .in_valid(inValid),
    .in_ready(readyA), .out_data(dataA), .out_valid(validA), .out_ready(outReady),
    .flush(flush), .sel_err(errA)
  );

  mux_n_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .RESET_VALUE(RVB)) dutB (
    .clock(clock), .reset(reset), .in_bus(inBus[95:0]), .sel(sel), .in_valid(inValid),
    .in_ready(readyB), .out_data(dataB), .out_valid(validB), .out_ready(outReady),
    .flush(flush), .sel_err(errB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    qa.delete();
    qb.delete();
    lastA   = RVA;
    lastB   = RVB;
    expErrA = 1'b0;
    expErrB = 1'b0;
  endtask

  // Words are held in arrival order; the head is what the output shows.
  task automatic modelStep();
    logic accA, accB;
    if (flush) begin
      modelClear();
    end else begin
      accA    = inValid && (qa.size() < 2);
      accB    = inValid && (qb.size() < 2);
      expErrA = 1'b0;
      expErrB = accB && (int'(sel) >= 3);
      if (qa.size() > 0 && outReady) lastA = qa.pop_front();
      if (qb.size() > 0 && outReady) lastB = qb.pop_front();
      if (accA) qa.push_back(inBus[int'(sel)*32 +: 32]);
      if (accB) qb.push_back((int'(sel) < 3) ? inBus[int'(sel)*32 +: 32] : RVB);
    end
  endtask

  task automatic checkAll();
    checkOutput("validA", {31'b0, validA}, (qa.size() > 0) ? 32'd1 : 32'd0);
    checkOutput("readyA", {31'b0, readyA}, (qa.size() < 2) ? 32'd1 : 32'd0);
    checkOutput("dataA",  dataA, (qa.size() > 0) ? qa[0] : lastA);
    checkOutput("errA",   {31'b0, errA}, {31'b0, expErrA});
    checkOutput("validB", {31'b0, validB}, (qb.size() > 0) ? 32'd1 : 32'd0);
    checkOutput("readyB", {31'b0, readyB}, (qb.size() < 2) ? 32'd1 : 32'd0);
    checkOutput("dataB",  dataB, (qb.size() > 0) ? qb[0] : lastB);
    checkOutput("errB",   {31'b0, errB}, {31'b0, expErrB});
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic ordy, input logic fl);
    inValid  = v;
    sel      = s;
    outReady = ordy;
    flush    = fl;
    @(posedge clock);
    modelStep();
    #1;
    checkAll();
  endtask

  initial begin
    reset    = 1'b1;
    inBus    = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    sel      = 2'd0;
    inValid  = 1'b0;
    outReady = 1'b1;
    flush    = 1'b0;
    modelClear();
    #12;
    checkAll();
    reset = 1'b0;

    // Idle after reset
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

    // Single word, sel=2 -> C, then empty again
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
    checkOutput("singleC", dataA, 32'h3333_3333);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

    // Streaming 0..3 at full rate
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), 1'b1, 1'b0);
    checkOutput("streamD", dataA, 32'h4444_4444);
    checkOutput("streamErrB", {31'b0, errB}, 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("errPulseB", {31'b0, errB}, 32'd0);

    // Backpressure: sel=1 then sel=3 fills the skid, then drain
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("holdB", dataA, 32'h2222_2222);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("drainD", dataA, 32'h4444_4444);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

    // Flush in TWO with a word presented
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b1);
    checkOutput("flushData", dataA, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

    // Asynchronous reset while in TWO
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    reset = 1'b1;
    modelClear();
    #1;
    checkAll();
    @(posedge clock);
    #1;
    checkAll();
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      inBus = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
